fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default `XLEN (32), instruction/address width.
REQ-002 Parameter DEPTH, default 4, queue entries; SHALL be a power of two >= 2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 imem_req_valid  out  1  fetch request valid.
REQ-007 imem_req_ready  in  1  memory accepts request.
REQ-008 imem_req_addr  out  XLEN  fetch address, bits[1:0] always 0.
REQ-009 imem_rsp_valid  in  1  in-order response; always accepted, no back-pressure.
REQ-010 imem_rsp_data  in  XLEN  returned instruction.
REQ-011 redirect_valid  in  1  branch/jump redirect (pc_sel != PC+4).
REQ-012 redirect_pc  in  XLEN  redirect target.
REQ-013 deq_valid  out  1  instruction available to decode.
REQ-014 deq_ready  in  1  decode accepts instruction.
REQ-015 deq_pc  out  XLEN  PC of deq_instr.
REQ-016 deq_instr  out  XLEN  instruction.
REQ-017 count  out  $clog2(DEPTH+1)  valid queue entries.

Function
REQ-018 Request fires on imem_req_valid && imem_req_ready; fetch_pc then advances by 4, modulo 2^XLEN.
REQ-019 imem_req_valid SHALL be 1 iff count + inflight < DEPTH and redirect_valid == 0.
REQ-020 imem_req_addr SHALL hold stable while imem_req_valid && !imem_req_ready, except when a redirect deasserts valid.
REQ-021 inflight counts fired requests without a response, including responses marked for discard.
REQ-022 Each kept response is written to the queue with rsp_pc, which then advances by 4.
REQ-023 A response arriving in cycle N SHALL be visible on deq_* in cycle N+1 (no combinational rsp->deq path).
REQ-024 Dequeue fires on deq_valid && deq_ready; simultaneous enqueue and dequeue leave count unchanged.
REQ-025 The credit rule of REQ-019 guarantees no overflow; a write to a full queue is a design error and SHALL be asserted against.
REQ-026 On redirect_valid in cycle N: queue flushed, count = 0, fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2], 2'b00}, drop_cnt = inflight - (imem_rsp_valid ? 1 : 0), all from N+1.
REQ-027 deq_valid SHALL be 0 during any cycle with redirect_valid = 1; no dequeue fires in that cycle.
REQ-028 A response arriving with drop_cnt > 0, or in the redirect cycle, SHALL be discarded; drop_cnt decrements if nonzero.
REQ-029 Back-to-back redirects: the later one wins; drop_cnt is recomputed per REQ-026.
REQ-030 With DEPTH = 4 and a 1-cycle memory, sustained throughput SHALL be one instruction per cycle.

Reset
REQ-031 While rst = 1: fetch_pc = rsp_pc = RESET_PC, count = inflight = drop_cnt = 0, imem_req_valid = deq_valid = 0.
REQ-032 First cycle after rst deasserts: imem_req_valid = 1, imem_req_addr = RESET_PC.
REQ-033 Reset mid-operation discards all queued and in-flight state; late responses after reset are a memory-side contract violation.

Structure
REQ-034 XLEN default, ILEN_BYTES = 4 and RESET_PC default SHALL live in the shared constants package/header.
REQ-035 Storage SHALL be one sub-module, sync_fifo (DATA_W = 2*XLEN, DEPTH), with synchronous flush and a count output.

Verification
REQ-036 Reset then always-ready 1-cycle memory -> requests at 0x0, 0x4, 0x8…; deq_pc 0x0 with its instruction first, visible 2 cycles after the first request.
REQ-037 deq_ready = 0 for 10 cycles, DEPTH = 4 -> count saturates at 4, imem_req_valid = 0, no overflow, no lost instruction.
REQ-038 Redirect to 0x103 with 3 requests in flight -> next request addr 0x100; 3 responses discarded; first deq_pc = 0x100.
REQ-039 Redirect coincident with a response and deq_ready = 1 -> response dropped, deq_valid = 0 that cycle, count = 0 next cycle.
REQ-040 fetch_pc = 0xFFFFFFFC, XLEN = 32 -> next request addr 0x00000000.
REQ-041 rst asserted mid-stream with 2 queued entries -> outputs cleared asynchronously; after release, first request = RESET_PC.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue.
package fetch_queue_pkg;

    localparam int unsigned XLEN_DEFAULT     = 32;
    localparam int unsigned ILEN_BYTES       = 4;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous flush and occupancy count; head entry is
// always presented on rdata.
module sync_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> !full);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// capture into a queue, and redirect handling with discard of stale responses.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEFAULT,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT[XLEN-1:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [XLEN-1:0]            imem_req_addr,
    input  logic                       imem_rsp_valid,
    input  logic [XLEN-1:0]            imem_rsp_data,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [XLEN-1:0]            deq_pc,
    output logic [XLEN-1:0]            deq_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned     CW      = $clog2(DEPTH+1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(ILEN_BYTES);
    localparam logic [XLEN-1:0] PC_MASK = ~XLEN'(ILEN_BYTES - 1);

    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     inflight_q, inflight_d, drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       credit_used;
    logic [2*XLEN-1:0] fifo_rdata;
    logic              fifo_empty;
    logic              req_fire, rsp_keep, deq_fire;

    // Queued plus outstanding entries may never exceed the queue capacity.
    assign credit_used    = {1'b0, fifo_count} + {1'b0, inflight_q};
    assign imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep  = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
    assign deq_valid = !fifo_empty && !redirect_valid;
    assign deq_fire  = deq_valid && deq_ready;
    assign deq_pc    = fifo_rdata[2*XLEN-1:XLEN];
    assign deq_instr = fifo_rdata[XLEN-1:0];
    assign count     = fifo_count;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        drop_cnt_d = drop_cnt_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & PC_MASK;
            rsp_pc_d   = redirect_pc & PC_MASK;
            // Everything still outstanding after this cycle belongs to the old path.
            drop_cnt_d = inflight_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
            if (rsp_keep) rsp_pc_d = rsp_pc_q + PC_STEP;
            if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC & PC_MASK;
            rsp_pc_q   <= RESET_PC & PC_MASK;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .DATA_W(2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(redirect_valid),
        .push (rsp_keep),
        .wdata({rsp_pc_q, imem_rsp_data}),
        .pop  (deq_fire),
        .rdata(fifo_rdata),
        .empty(fifo_empty),
        .count(fifo_count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner-case sequences and
// randomized traffic against a request/response-list reference model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq_valid, deq_ready;
    logic [31:0] deq_pc, deq_instr;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_queue #(
        .XLEN    (32),
        .DEPTH   (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .deq_valid     (deq_valid),
        .deq_ready     (deq_ready),
        .deq_pc        (deq_pc),
        .deq_instr     (deq_instr),
        .count         (count)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        rq_ready;
        logic        rsp_v;
        logic        dq_ready;
        logic        exp_req_valid;
        logic [31:0] exp_addr;
        logic        exp_deq_valid;
        logic [31:0] exp_deq_pc;
        int          exp_count;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_fetch_pc;
    req_t        outst[$];
    ent_t        q[$];
    vec_t        tbl[11];

    logic        obs_req_valid, obs_deq_valid;
    logic [31:0] obs_req_addr, obs_deq_pc;
    logic [2:0]  obs_count;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hD000_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        outst.delete();
        q.delete();
        m_fetch_pc = 32'h0;
    endtask

    // One clock cycle: entered and left at the falling edge.
    task automatic step(input logic rq_ready, input logic rsp_v, input logic dq_ready,
                        input logic redir, input logic [31:0] rpc);
        logic e_req_valid, e_deq_valid, rv;
        req_t r;
        rv = rsp_v && (outst.size() > 0);
        imem_req_ready = rq_ready;
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? mem_word(outst[0].addr) : 32'h0;
        deq_ready      = dq_ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
        e_req_valid = !redir && ((q.size() + outst.size()) < 4);
        e_deq_valid = !redir && (q.size() > 0);
        #1;
        obs_req_valid = imem_req_valid;
        obs_req_addr  = imem_req_addr;
        obs_deq_valid = deq_valid;
        obs_deq_pc    = deq_pc;
        obs_count     = count;
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, e_req_valid});
        if (e_req_valid) check("req_addr", imem_req_addr, m_fetch_pc);
        check("deq_valid", {31'b0, deq_valid}, {31'b0, e_deq_valid});
        if (e_deq_valid) begin
            check("deq_pc", deq_pc, q[0].pc);
            check("deq_instr", deq_instr, q[0].instr);
        end
        check("count", {29'b0, count}, q.size());
        if (redir) begin
            if (rv) void'(outst.pop_front());
            foreach (outst[i]) outst[i].stale = 1'b1;
            q.delete();
            m_fetch_pc = rpc & ~32'h3;
        end else begin
            if (e_deq_valid && dq_ready) void'(q.pop_front());
            if (rv) begin
                r = outst.pop_front();
                if (!r.stale) q.push_back('{r.addr, mem_word(r.addr)});
            end
            if (e_req_valid && rq_ready) begin
                outst.push_back('{m_fetch_pc, 1'b0});
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        deq_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_deq_valid", {31'b0, deq_valid}, 32'h0);
        check("rst_count", {29'b0, count}, 32'h0);
        check("rst_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Always-ready memory, then a decode stall that fills the queue.
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h8, 1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h8, 2};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h18, 1'b1, 32'h8, 3};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h18, 1'b1, 32'h8, 4};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h18, 1'b1, 32'h8, 4};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h18, 1'b1, 32'h8, 4};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'hC, 3};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].rq_ready, tbl[i].rsp_v, tbl[i].dq_ready, 1'b0, 32'h0);
            check("tbl_req_valid", {31'b0, obs_req_valid}, {31'b0, tbl[i].exp_req_valid});
            check("tbl_req_addr", obs_req_addr, tbl[i].exp_addr);
            check("tbl_deq_valid", {31'b0, obs_deq_valid}, {31'b0, tbl[i].exp_deq_valid});
            if (tbl[i].exp_deq_valid) check("tbl_deq_pc", obs_deq_pc, tbl[i].exp_deq_pc);
            check("tbl_count", {29'b0, obs_count}, tbl[i].exp_count);
        end

        // Redirect to an unaligned target with three requests outstanding.
        reset_dut();
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h103);
        check("redir_req_valid", {31'b0, obs_req_valid}, 32'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("redir_addr", obs_req_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            if (obs_deq_valid) begin
                found = 1'b1;
                check("redir_first_pc", obs_deq_pc, 32'h100);
            end
        end
        check("redir_deq_seen", {31'b0, found}, 32'h1);

        // Redirect in the same cycle as a response, with decode ready.
        reset_dut();
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
        check("coinc_deq_valid", {31'b0, obs_deq_valid}, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check("coinc_count", {29'b0, obs_count}, 32'h0);
        check("coinc_addr", obs_req_addr, 32'h40);
        repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Fetch address wrap-around.
        reset_dut();
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("wrap_addr0", obs_req_addr, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("wrap_addr1", obs_req_addr, 32'h0);
        repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);

        // Asynchronous reset with two entries queued.
        reset_dut();
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        idle_inputs();
        #1;
        check("pre_rst_count", {29'b0, count}, 32'h2);
        #1 rst = 1'b1;
        #1;
        check("async_count", {29'b0, count}, 32'h0);
        check("async_deq_valid", {31'b0, deq_valid}, 32'h0);
        check("async_req_valid", {31'b0, imem_req_valid}, 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        check("post_rst_valid", {31'b0, obs_req_valid}, 32'h1);
        check("post_rst_addr", obs_req_addr, 32'h0);

        // Randomized traffic against the reference model.
        reset_dut();
        repeat (3000) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
